// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data_cache <-> main memory request/response interface.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        WACK
    } mem_state_t;

    localparam int unsigned MEM_DATA_WIDTH   = 32;
    localparam int unsigned MEM_ADDR_WIDTH   = 17;
    localparam int unsigned MEM_LINE_WORDS   = 4;
    localparam int unsigned WSTRB_WIDTH      = MEM_DATA_WIDTH / 8;
    localparam int unsigned LINE_OFFSET_BITS = $clog2(MEM_LINE_WORDS * WSTRB_WIDTH);

    typedef struct packed {
        logic                      we;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_DATA_WIDTH-1:0] wdata;
        logic [WSTRB_WIDTH-1:0]    wstrb;
    } mem_req_t;

    // Counter width that stays legal (>= 1 bit) when the count range is a single value.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised backing store with byte strobes: combinational word read, synchronous strobed write.
module mem_byte_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_AW    = 15
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [WORD_AW-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [WORD_AW-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    // Contents survive reset on purpose, so there is no reset term here.
    logic [DATA_WIDTH-1:0] mem_q [0:(2**WORD_AW)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/main_mem_responder.sv
// Far-side memory responder for data_cache: line-refill bursts and write-through acks
// returned after a programmable access latency over valid/ready channels.
module main_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_last,
    output logic                    resp_is_wr
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned BYTE_BITS = $clog2(BYTES);
    localparam int unsigned WORD_AW   = ADDR_WIDTH - BYTE_BITS;
    localparam int unsigned BEAT_W    = clog2_min1(LINE_WORDS);
    localparam int unsigned CNT_W     = clog2_min1(LATENCY);

    localparam logic [BEAT_W-1:0]  LAST_BEAT       = BEAT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]   CNT_INIT        = CNT_W'(LATENCY - 1);
    localparam logic [WORD_AW-1:0] WORD_LINE_MASK  = ~WORD_AW'(LINE_WORDS - 1);

    mem_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WORD_AW-1:0]  addr_q, addr_d;
    logic                we_q, we_d;
    logic                en_q;

    logic                mem_we;
    logic [WORD_AW-1:0]  rd_word;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Addresses are held as word indices; byte-offset bits never select storage.
    if (BYTE_BITS > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^req_addr[BYTE_BITS-1:0];
    end

    // Line base is word-aligned to the line, so adding the beat index never carries past it.
    assign rd_word = (addr_q & WORD_LINE_MASK) + WORD_AW'(beat_q);

    mem_byte_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_AW    (WORD_AW)
    ) u_store (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (req_addr[ADDR_WIDTH-1:BYTE_BITS]),
        .wdata_i (req_wdata),
        .wstrb_i (req_wstrb),
        .raddr_i (rd_word),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        we_d       = we_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_last  = 1'b0;
        resp_is_wr = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = en_q;
                if (req_valid && en_q) begin
                    addr_d  = req_addr[ADDR_WIDTH-1:BYTE_BITS];
                    we_d    = req_we;
                    cnt_d   = CNT_INIT;
                    beat_d  = '0;
                    mem_we  = req_we;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = we_q ? WACK : BURST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BURST: begin
                resp_valid = 1'b1;
                resp_rdata = mem_rdata;
                resp_last  = (beat_q == LAST_BEAT);
                if (resp_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            WACK: begin
                resp_valid = 1'b1;
                resp_last  = 1'b1;
                resp_is_wr = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Backing-store responder on the far side of data_cache; data_cache is the initiator on this interface.
- Accepts line-refill read requests and write-through word writes over a valid/ready request channel.
- Returns refill data as a fixed-length beat burst, and write acknowledgements, after a programmable access latency.
- Replaces the zero-latency data_mem path so miss penalty and write-through cost become visible to the pipeline.

Parameters:
- DATA_WIDTH, 32, word width of the request/response data.
- ADDR_WIDTH, 17, byte-address width; storage is 2**ADDR_WIDTH bytes.
- LINE_WORDS, 4, words per refill burst; power of two, at least 1.
- LATENCY, 4, cycles between request acceptance and the first response beat; at least 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = word write, 0 = line read.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  write data, little-endian.
- req_wstrb  input  DATA_WIDTH/8  byte enables for writes.
- resp_valid  output  1  response beat present.
- resp_ready  input  1  initiator accepts the beat.
- resp_rdata  output  DATA_WIDTH  read beat data; 0 on write acks.
- resp_last  output  1  final beat of a response.
- resp_is_wr  output  1  beat is a write ack.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=0 while rst=0, then 1 from the first cycle after release.
  - resp_valid=0, resp_rdata=0, resp_last=0, resp_is_wr=0.
  - Storage contents are not cleared.
  - An in-flight burst or ack is abandoned with no further beats.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready. A transfer beat occurs on a rising edge with resp_valid && resp_ready.
  - One outstanding request only; req_ready=1 only in IDLE.
  - Once resp_valid rises, resp_valid, resp_rdata, resp_last and resp_is_wr stay stable until that beat is accepted.
- State IDLE:
  - On accept, latch the request and load the latency counter with LATENCY-1, then go to WAIT.
  - For writes, commit the enabled bytes to storage on the accepting edge.
- State WAIT:
  - The counter decrements each cycle.
  - At 0, go to BURST for a read or WACK for a write. The first beat is therefore visible LATENCY cycles after the accept edge.
- State BURST:
  - Base = req_addr with the low log2(LINE_WORDS*4) bits forced to 0.
  - Beat i returns the word at base + 4*i, i = 0..LINE_WORDS-1, in ascending order with no critical-word-first.
  - The beat index advances only on beat transfer.
  - resp_last=1 on beat LINE_WORDS-1; its transfer returns the FSM to IDLE.
- State WACK:
  - One beat: resp_is_wr=1, resp_last=1, resp_rdata=0.
  - Transfer returns the FSM to IDLE.
- Addressing:
  - Only ADDR_WIDTH bits are used; the offset add wraps modulo 2**ADDR_WIDTH.
  - The word-offset bits [1:0] are ignored for both reads and writes; writes are word-aligned with strobes.
- Back-to-back: a request arriving on the same edge as the last beat transfer is not accepted (req_ready=0 that cycle). It is accepted on the next edge, giving a one-cycle IDLE bubble.
- Read-after-write: a read accepted after a write ack returns the updated bytes.
- req_wstrb=0: the write is still acknowledged; storage is unchanged.
- Backpressure: resp_ready=0 holds the current beat indefinitely, with no timeout.

Decomposition:
- Shared package mem_if_pkg:
  - typedef mem_state_t {IDLE, WAIT, BURST, WACK}.
  - Constants LINE_OFFSET_BITS and WSTRB_WIDTH.
  - Request struct {we, addr, wdata, wstrb} for reuse by data_cache.
- One sub-module is natural: mem_byte_array, the byte-addressable storage with one combinational word read port and one strobed synchronous write port. The FSM, latency counter and beat counter stay in main_mem_responder.

Test Plan:
- Reset: hold rst=0 mid-burst, then release -> resp_valid=0 immediately; req_ready=1 on the first cycle after release; no stale beats.
- Read latency: preload 0x100..0x10C = 0x11,0x22,0x33,0x44; read at 0x108 with LATENCY=4 and resp_ready=1 -> first beat 4 cycles after accept; beats 0x11,0x22,0x33,0x44; resp_last only on the 4th beat.
- Strobed write then read:
  - Start with 0xAABBCCDD at 0x200.
  - Write 0x11223344 with wstrb=4'b0101 -> single ack with resp_is_wr=1, resp_last=1, resp_rdata=0.
  - A following read of line 0x200 returns 0xAA22CC44 as beat 0.
- Backpressure: resp_ready=0 for 5 cycles on beat 2 -> beat 2 data and resp_valid stable across all 5 cycles; the burst completes with the correct order.
- Back-to-back: the next read is presented during the final beat -> not accepted that edge; accepted on the next edge; one-cycle req_ready bubble.
- Wrap and zero strobe:
  - Read at 2**17-4 -> base 0x1FFF0; beats from 0x1FFF0..0x1FFFC.
  - Write with wstrb=0 -> acknowledged; contents unchanged.
